// File: rtl/polara_noc_traffic_gen_pkg.sv
// Shared definitions for the Polara NoC traffic generator: FSM states, header field layout
// and message-type constants.
package polara_noc_traffic_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PKT_END = 3'd3,
    ST_GAP     = 3'd4,
    ST_WAIT_RX = 3'd5,
    ST_DONE    = 3'd6
  } tgen_state_e;

  localparam int HDR_W        = 64;
  localparam int HDR_MSHR_LSB = 6;
  localparam int HDR_MSHR_W   = 8;
  localparam int HDR_MSG_LSB  = 14;
  localparam int HDR_MSG_W    = 8;
  localparam int HDR_LEN_LSB  = 22;
  localparam int HDR_LEN_W    = 8;
  localparam int HDR_CHIP_LSB = 50;
  localparam int HDR_CHIP_W   = 14;

  localparam logic [7:0] MSG_TYPE_LOAD_REQ  = 8'd31;
  localparam logic [7:0] MSG_TYPE_STORE_REQ = 8'd2;

  // X, Y and FBITS are always zero for traffic sourced from the chipset side
  function automatic logic [HDR_W-1:0] make_hdr(input logic [HDR_CHIP_W-1:0] chipid,
                                                input logic [HDR_LEN_W-1:0]  len,
                                                input logic [HDR_MSG_W-1:0]  msg,
                                                input logic [HDR_MSHR_W-1:0] mshr);
    return {chipid, 8'd0, 8'd0, 4'd0, len, msg, mshr, 6'd0};
  endfunction

endpackage

// File: rtl/polara_noc_rx_parser.sv
// Per-channel return-traffic sink: follows header/body position and pulses pkt_done
// on the flit that completes a packet.
module polara_noc_rx_parser
  import polara_noc_traffic_gen_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] data,
  input  logic              val,
  output logic              pkt_done
);

  logic                 in_body_r;
  logic [HDR_LEN_W-1:0] remain_r;
  logic [HDR_LEN_W-1:0] hdr_len_s;
  logic                 unused_data_s;

  assign hdr_len_s     = data[HDR_LEN_LSB +: HDR_LEN_W];
  assign unused_data_s = ^{data[DATA_W-1:HDR_LEN_LSB+HDR_LEN_W], data[HDR_LEN_LSB-1:0]};

  // Completion of the flit accepted this cycle; a zero-length header completes on its own
  always_comb begin
    pkt_done = 1'b0;
    if (!val) begin
      pkt_done = 1'b0;
    end else if (in_body_r) begin
      pkt_done = (remain_r == 8'd1);
    end else begin
      pkt_done = (hdr_len_s == 8'd0);
    end
  end

  // Header/body tracking with remaining-flit count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_body_r <= 1'b0;
      remain_r  <= 8'd0;
    end else if (clr) begin
      in_body_r <= 1'b0;
      remain_r  <= 8'd0;
    end else if (val) begin
      if (in_body_r) begin
        remain_r  <= remain_r - 8'd1;
        in_body_r <= (remain_r != 8'd1);
      end else begin
        remain_r  <= hdr_len_s;
        in_body_r <= (hdr_len_s != 8'd0);
      end
    end
  end

endmodule

// File: rtl/polara_noc_traffic_gen.sv
// NoC traffic generator/sink: sends cfg_pkt_num packets on one channel, counts return
// packets on all channels and reports done/timeout.
module polara_noc_traffic_gen
  import polara_noc_traffic_gen_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 65535,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     chipset_clk,
  input  logic                     chipset_rst_n,
  input  logic                     start,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [CNT_W-1:0]         cfg_pkt_num,
  input  logic [7:0]               cfg_len,
  input  logic [7:0]               cfg_msg_type,
  input  logic [13:0]              cfg_chipid,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  output logic [NUM_CH-1:0]        tx_val,
  input  logic [NUM_CH-1:0]        tx_rdy,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  input  logic [NUM_CH-1:0]        rx_val,
  output logic [NUM_CH-1:0]        rx_rdy,
  output logic [CNT_W-1:0]         tx_pkt_cnt,
  output logic [CNT_W-1:0]         rx_pkt_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  tgen_state_e         state_r;
  logic [CH_W-1:0]     ch_r;
  logic [CNT_W-1:0]    pkt_num_r;
  logic [7:0]          len_r;
  logic [7:0]          msg_r;
  logic [13:0]         chipid_r;
  logic [7:0]          flit_idx_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [TMO_W-1:0]    idle_cnt_r;
  logic [DATA_W-1:0]   flit_r;
  logic [NUM_CH-1:0]   tx_val_r;
  logic [NUM_CH-1:0]   rx_rdy_r;
  logic [CNT_W-1:0]    tx_pkt_cnt_r;
  logic [CNT_W-1:0]    rx_pkt_cnt_r;
  logic                busy_r;
  logic                done_r;
  logic                timeout_r;

  logic                start_ok_s;
  logic                xfer_s;
  logic [NUM_CH-1:0]   rx_acc_s;
  logic [NUM_CH-1:0]   pkt_done_s;
  logic [CNT_W:0]      next_seq_s;
  logic                more_s;
  logic [TMO_W-1:0]    idle_nxt_s;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    return {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
  endfunction

  function automatic logic [DATA_W-1:0] make_payload(input logic [CNT_W-1:0] seq,
                                                     input logic [7:0]       idx);
    return DATA_W'({seq, idx});
  endfunction

  assign start_ok_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign xfer_s     = |(tx_val_r & tx_rdy);
  assign rx_acc_s   = rx_val & rx_rdy_r;
  assign next_seq_s = {1'b0, tx_pkt_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
  assign more_s     = next_seq_s < {1'b0, pkt_num_r};

  // Quiet-period timer holds at TIMEOUT once reached
  always_comb begin
    idle_nxt_s = idle_cnt_r;
    if (idle_cnt_r == TMO_W'(TIMEOUT)) begin
      idle_nxt_s = idle_cnt_r;
    end else begin
      idle_nxt_s = idle_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    polara_noc_rx_parser #(.DATA_W(DATA_W)) u_rx_parser (
      .clk      (chipset_clk),
      .rst_n    (chipset_rst_n),
      .clr      (start_ok_s),
      .data     (rx_data[g*DATA_W +: DATA_W]),
      .val      (rx_acc_s[g]),
      .pkt_done (pkt_done_s[g])
    );
    assign tx_data[g*DATA_W +: DATA_W] = (ch_r == CH_W'(g)) ? flit_r : {DATA_W{1'b0}};
  end

  // RX sink: always ready once out of reset, completions summed across channels
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      rx_rdy_r     <= {NUM_CH{1'b0}};
      rx_pkt_cnt_r <= {CNT_W{1'b0}};
    end else begin
      rx_rdy_r <= {NUM_CH{1'b1}};
      if (start_ok_s) begin
        rx_pkt_cnt_r <= {CNT_W{1'b0}};
      end else begin
        rx_pkt_cnt_r <= sat_add(rx_pkt_cnt_r, CNT_W'($countones(pkt_done_s)));
      end
    end
  end

  // TX sequencer with registered status outputs
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      state_r      <= ST_IDLE;
      ch_r         <= {CH_W{1'b0}};
      pkt_num_r    <= {CNT_W{1'b0}};
      len_r        <= 8'd0;
      msg_r        <= 8'd0;
      chipid_r     <= 14'd0;
      flit_idx_r   <= 8'd0;
      gap_cnt_r    <= {GAP_W{1'b0}};
      idle_cnt_r   <= {TMO_W{1'b0}};
      flit_r       <= {DATA_W{1'b0}};
      tx_val_r     <= {NUM_CH{1'b0}};
      tx_pkt_cnt_r <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ch_r         <= cfg_ch;
            pkt_num_r    <= cfg_pkt_num;
            len_r        <= cfg_len;
            msg_r        <= cfg_msg_type;
            chipid_r     <= cfg_chipid;
            flit_idx_r   <= 8'd0;
            tx_pkt_cnt_r <= {CNT_W{1'b0}};
            timeout_r    <= 1'b0;
            if (cfg_pkt_num == {CNT_W{1'b0}}) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r  <= ST_HDR;
              busy_r   <= 1'b1;
              done_r   <= 1'b0;
              tx_val_r <= ch_onehot(cfg_ch);
              flit_r   <= DATA_W'(make_hdr(cfg_chipid, cfg_len, cfg_msg_type, 8'd0));
            end
          end
        end
        ST_HDR: begin
          if (xfer_s) begin
            if (len_r != 8'd0) begin
              state_r    <= ST_PAYLOAD;
              flit_idx_r <= 8'd0;
              flit_r     <= make_payload(tx_pkt_cnt_r, 8'd0);
            end else begin
              state_r  <= ST_PKT_END;
              tx_val_r <= {NUM_CH{1'b0}};
            end
          end
        end
        ST_PAYLOAD: begin
          if (xfer_s) begin
            if (flit_idx_r == len_r - 8'd1) begin
              state_r  <= ST_PKT_END;
              tx_val_r <= {NUM_CH{1'b0}};
            end else begin
              flit_idx_r <= flit_idx_r + 8'd1;
              flit_r     <= make_payload(tx_pkt_cnt_r, flit_idx_r + 8'd1);
            end
          end
        end
        ST_PKT_END: begin
          tx_pkt_cnt_r <= sat_add(tx_pkt_cnt_r, {{(CNT_W-1){1'b0}}, 1'b1});
          gap_cnt_r    <= {GAP_W{1'b0}};
          idle_cnt_r   <= {TMO_W{1'b0}};
          if (!more_s) begin
            state_r <= ST_WAIT_RX;
          end else if (GAP_CYC == 0) begin
            state_r  <= ST_HDR;
            tx_val_r <= ch_onehot(ch_r);
            flit_r   <= DATA_W'(make_hdr(chipid_r, len_r, msg_r, next_seq_s[7:0]));
          end else begin
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_W'(GAP_CYC - 1)) begin
            state_r  <= ST_HDR;
            tx_val_r <= ch_onehot(ch_r);
            flit_r   <= DATA_W'(make_hdr(chipid_r, len_r, msg_r, tx_pkt_cnt_r[7:0]));
          end else begin
            gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WAIT_RX: begin
          if (rx_pkt_cnt_r >= tx_pkt_cnt_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (|rx_acc_s) begin
            idle_cnt_r <= {TMO_W{1'b0}};
          end else if (idle_nxt_s == TMO_W'(TIMEOUT)) begin
            idle_cnt_r <= idle_nxt_s;
            state_r    <= ST_DONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            timeout_r  <= 1'b1;
          end else begin
            idle_cnt_r <= idle_nxt_s;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tx_val_r <= {NUM_CH{1'b0}};
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_val     = tx_val_r;
  assign rx_rdy     = rx_rdy_r;
  assign tx_pkt_cnt = tx_pkt_cnt_r;
  assign rx_pkt_cnt = rx_pkt_cnt_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_polara_noc_traffic_gen.sv
// Directed bench for polara_noc_traffic_gen with a transfer log, hold-stability monitor
// and an optional 10-cycle loopback onto RX channel 2.
module tb_polara_noc_traffic_gen;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    cfg_ch;
  logic [15:0]   cfg_pkt_num;
  logic [7:0]    cfg_len;
  logic [7:0]    cfg_msg_type;
  logic [13:0]   cfg_chipid;
  logic [191:0]  tx_data;
  logic [2:0]    tx_val;
  logic [2:0]    tx_rdy;
  logic [191:0]  rx_data;
  logic [2:0]    rx_val;
  logic [2:0]    rx_rdy;
  logic [15:0]   tx_pkt_cnt;
  logic [15:0]   rx_pkt_cnt;
  logic          busy;
  logic          done;
  logic          timeout;

  logic [191:0]  tb_rx_data;
  logic [2:0]    tb_rx_val;
  logic [191:0]  lb_data;
  logic [2:0]    lb_val;
  logic          loop_en;

  int            n_checks;
  int            n_fail;
  int            cyc;
  logic [63:0]   log_data[$];
  int            log_ch[$];
  int            log_cyc[$];
  logic [63:0]   lb_q[$];
  int            lb_due[$];
  logic [2:0]    prev_val;
  logic [2:0]    prev_rdy;
  logic [191:0]  prev_data;

  // chipid 0x0ABC, msg 0x2A, X/Y/FBITS 0
  localparam logic [63:0] HDR_L0_S0 = 64'h2AF0_0000_000A_8000;
  localparam logic [63:0] HDR_L0_S1 = 64'h2AF0_0000_000A_8040;
  localparam logic [63:0] HDR_L0_S2 = 64'h2AF0_0000_000A_8080;
  localparam logic [63:0] HDR_L2_S0 = 64'h2AF0_0000_008A_8000;

  assign rx_val  = tb_rx_val | lb_val;
  assign rx_data = tb_rx_data | lb_data;

  polara_noc_traffic_gen #(.TIMEOUT(100)) dut (
    .chipset_clk   (clk),
    .chipset_rst_n (rst_n),
    .start         (start),
    .cfg_ch        (cfg_ch),
    .cfg_pkt_num   (cfg_pkt_num),
    .cfg_len       (cfg_len),
    .cfg_msg_type  (cfg_msg_type),
    .cfg_chipid    (cfg_chipid),
    .tx_data       (tx_data),
    .tx_val        (tx_val),
    .tx_rdy        (tx_rdy),
    .rx_data       (rx_data),
    .rx_val        (rx_val),
    .rx_rdy        (rx_rdy),
    .tx_pkt_cnt    (tx_pkt_cnt),
    .rx_pkt_cnt    (rx_pkt_cnt),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: logs transfers, feeds loopback, checks hold while stalled
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (prev_val[i] && !prev_rdy[i]) begin
          check_eq("hold_val", {63'd0, tx_val[i]}, 64'd1);
          check_eq("hold_data", tx_data[i*64 +: 64], prev_data[i*64 +: 64]);
        end
        if (tx_val[i] && tx_rdy[i]) begin
          log_data.push_back(tx_data[i*64 +: 64]);
          log_ch.push_back(i);
          log_cyc.push_back(cyc);
          if (loop_en) begin
            lb_q.push_back(tx_data[i*64 +: 64]);
            lb_due.push_back(cyc + 10);
          end
        end
      end
      prev_val  <= tx_val;
      prev_rdy  <= tx_rdy;
      prev_data <= tx_data;
    end else begin
      prev_val <= 3'b000;
    end
  end

  // Loopback: replay each sent flit on RX channel 2 ten cycles later
  always @(negedge clk) begin
    if (lb_due.size() != 0 && cyc >= lb_due[0]) begin
      lb_val  <= 3'b100;
      lb_data <= {lb_q[0], 128'd0};
      void'(lb_q.pop_front());
      void'(lb_due.pop_front());
    end else begin
      lb_val  <= 3'b000;
      lb_data <= 192'd0;
    end
  end

  task automatic do_start(input logic [1:0] ch, input logic [15:0] num, input logic [7:0] len);
    cfg_ch       = ch;
    cfg_pkt_num  = num;
    cfg_len      = len;
    cfg_msg_type = 8'h2A;
    cfg_chipid   = 14'h0ABC;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    check_eq("done_wait", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int base;
    n_checks = 0; n_fail = 0; cyc = 0;
    prev_val = 3'b000; prev_rdy = 3'b000; prev_data = 192'd0;
    lb_val = 3'b000; lb_data = 192'd0; loop_en = 1'b0;
    tb_rx_val = 3'b000; tb_rx_data = 192'd0;
    start = 1'b0; cfg_ch = 2'd0; cfg_pkt_num = 16'd0; cfg_len = 8'd0;
    cfg_msg_type = 8'd0; cfg_chipid = 14'd0; tx_rdy = 3'b111;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_tx_val", {61'd0, tx_val}, 64'd0);
    check_eq("rst_tx_data", tx_data[63:0] | tx_data[127:64] | tx_data[191:128], 64'd0);
    check_eq("rst_rx_rdy", {61'd0, rx_rdy}, 64'd0);
    check_eq("rst_flags", {61'd0, busy, done, timeout}, 64'd0);
    check_eq("rst_cnts", {32'd0, tx_pkt_cnt, rx_pkt_cnt}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rx_rdy_up", {61'd0, rx_rdy}, 64'd7);

    // three header-only packets on ch1, then no return traffic
    base = log_data.size();
    do_start(2'd1, 16'd3, 8'd0);
    check_eq("t1_first_val", {61'd0, tx_val}, 64'd2);
    check_eq("t1_first_hdr", tx_data[127:64], HDR_L0_S0);
    check_eq("t1_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check_eq("t1_pktend_val", {61'd0, tx_val}, 64'd0);
    check_eq("t1_pktend_cnt", {48'd0, tx_pkt_cnt}, 64'd0);
    repeat (13) @(negedge clk);
    check_eq("t1_tx_cnt", {48'd0, tx_pkt_cnt}, 64'd3);
    check_eq("t1_wait_flags", {62'd0, busy, done}, 64'd2);
    check_eq("t1_nxfer", 64'(log_data.size() - base), 64'd3);
    if (log_data.size() >= base + 3) begin
      check_eq("t1_ch0", 64'(log_ch[base]), 64'd1);
      check_eq("t1_ch1", 64'(log_ch[base+1]), 64'd1);
      check_eq("t1_ch2", 64'(log_ch[base+2]), 64'd1);
      check_eq("t1_hdr0", log_data[base], HDR_L0_S0);
      check_eq("t1_hdr1", log_data[base+1], HDR_L0_S1);
      check_eq("t1_hdr2", log_data[base+2], HDR_L0_S2);
      check_eq("t1_space01", 64'(log_cyc[base+1] - log_cyc[base]), 64'd6);
      check_eq("t1_space12", 64'(log_cyc[base+2] - log_cyc[base+1]), 64'd6);
    end
    // timeout exactly 100 cycles after entering WAIT_RX
    repeat (99) @(negedge clk);
    check_eq("t4_pre_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    check_eq("t4_done_tmo", {61'd0, busy, done, timeout}, 64'd3);

    // same traffic with loopback returning on rx ch2
    loop_en = 1'b1;
    do_start(2'd1, 16'd3, 8'd0);
    check_eq("t2_tmo_clr", {63'd0, timeout}, 64'd0);
    check_eq("t2_cnt_clr", {48'd0, tx_pkt_cnt}, 64'd0);
    wait_done(200);
    check_eq("t2_rx_cnt", {48'd0, rx_pkt_cnt}, 64'd3);
    check_eq("t2_tx_cnt", {48'd0, tx_pkt_cnt}, 64'd3);
    check_eq("t2_tmo", {63'd0, timeout}, 64'd0);

    // len=2 with tx_rdy toggling; a start while busy must be ignored
    tx_rdy = 3'b000;
    repeat (2) @(negedge clk);
    base = log_data.size();
    do_start(2'd0, 16'd1, 8'd2);
    for (int i = 0; i < 12; i++) begin
      start = (i == 2);
      if (i == 2) begin
        cfg_pkt_num = 16'd5;
        cfg_ch      = 2'd2;
      end
      tx_rdy = (i % 2 == 1) ? 3'b111 : 3'b000;
      @(negedge clk);
    end
    start  = 1'b0;
    tx_rdy = 3'b111;
    wait_done(100);
    check_eq("t3_nxfer", 64'(log_data.size() - base), 64'd3);
    if (log_data.size() >= base + 3) begin
      check_eq("t3_hdr", log_data[base], HDR_L2_S0);
      check_eq("t3_pl0", log_data[base+1], 64'h0);
      check_eq("t3_pl1", log_data[base+2], 64'h1);
      check_eq("t3_ch", 64'(log_ch[base] + log_ch[base+1] + log_ch[base+2]), 64'd0);
    end
    check_eq("t3_tx_cnt", {48'd0, tx_pkt_cnt}, 64'd1);
    check_eq("t3_rx_cnt", {48'd0, rx_pkt_cnt}, 64'd1);
    check_eq("t3_tmo", {63'd0, timeout}, 64'd0);
    loop_en = 1'b0;
    repeat (3) @(negedge clk);

    // zero packets: done right after start, nothing sent
    base = log_data.size();
    do_start(2'd2, 16'd0, 8'd0);
    check_eq("t5_done", {62'd0, busy, done}, 64'd1);
    check_eq("t5_no_val", {61'd0, tx_val}, 64'd0);
    check_eq("t5_rx_clr", {48'd0, rx_pkt_cnt}, 64'd0);
    @(negedge clk);
    check_eq("t5_no_xfer", 64'(log_data.size() - base), 64'd0);

    // async reset mid-payload
    do_start(2'd2, 16'd2, 8'd3);
    repeat (2) @(negedge clk);
    check_eq("t5_mid_val", {61'd0, tx_val}, 64'd4);
    check_eq("t5_mid_pl1", tx_data[191:128], 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_ar_val", {61'd0, tx_val}, 64'd0);
    check_eq("t5_ar_data", tx_data[63:0] | tx_data[127:64] | tx_data[191:128], 64'd0);
    check_eq("t5_ar_rdy", {61'd0, rx_rdy}, 64'd0);
    check_eq("t5_ar_flags", {61'd0, busy, done, timeout}, 64'd0);
    check_eq("t5_ar_cnt", {48'd0, tx_pkt_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // simultaneous single-flit packets on ch0 and ch2, then a 2-flit packet on ch1
    tb_rx_val  = 3'b101;
    tb_rx_data = {HDR_L0_S0, 64'd0, HDR_L0_S1};
    @(negedge clk);
    tb_rx_val  = 3'b000;
    tb_rx_data = 192'd0;
    check_eq("t6_dual", {48'd0, rx_pkt_cnt}, 64'd2);
    tb_rx_val  = 3'b010;
    tb_rx_data = {64'd0, 64'h0000_0000_0040_0000, 64'd0};
    @(negedge clk);
    check_eq("t6_hdr_only", {48'd0, rx_pkt_cnt}, 64'd2);
    tb_rx_data = {64'd0, 64'h0000_0000_3FC0_0000, 64'd0};
    @(negedge clk);
    tb_rx_val  = 3'b000;
    tb_rx_data = 192'd0;
    check_eq("t6_body", {48'd0, rx_pkt_cnt}, 64'd3);
    do_start(2'd0, 16'd0, 8'd0);
    check_eq("t6_start_clr", {48'd0, rx_pkt_cnt}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
